iob_eth_rx: RTL and testbench
=============================

// Module: iob_eth_rx
// PURPOSE
//   MII receive engine: deframes nibble stream from PHY (rx_dv_i/rx_data_i), strips preamble/SFD,
//   assembles bytes (low nibble first) and writes them into the RX frame buffer.
//   Runs CRC-32 over all post-SFD bytes (FCS included), reports length/CRC/overflow status
//   to the CSR side, holds frame until acknowledged. Receive-side peer of iob_eth_tx.
// PARAMETERS
//   BUF_AW        11   RX buffer address width (bytes); capacity 2**BUF_AW
//   PREAMBLE_MIN  2    min 0x5 nibbles before 0xD SFD nibble for frame to be accepted
// PORTS
//   rx_clk_i     in   1         MII RX clock; all logic on rising edge
//   rst_i        in   1         synchronous active-high reset
//   rx_dv_i      in   1         MII receive data valid
//   rx_data_i    in   4         MII receive nibble
//   rx_er_i      in   1         MII receive error
//   rcv_ack_i    in   1         CSR ack: frame consumed, buffer may be reused
//   wr_o         out  1         buffer write strobe
//   addr_o       out  BUF_AW    buffer byte address
//   data_o       out  8         buffer write byte
//   received_o   out  1         frame complete, status valid; held until rcv_ack_i
//   nbytes_o     out  BUF_AW+1  bytes written for last frame (FCS included)
//   crc_err_o    out  1         last frame failed FCS check / too short / rx_er_i seen
//   ovf_o        out  1         last frame exceeded buffer; excess bytes dropped
// BEHAVIOUR
//   Reset (rst_i=1 at edge): state IDLE; all outputs 0; byte count 0; CRC reg 32'hFFFFFFFF.
//   All outputs registered. Reset mid-frame aborts frame; rest of frame discarded (needs rx_dv_i low).
//   States:
//   IDLE: rx_dv_i=1 & nibble 0x5 -> PRE (pre_cnt=1); rx_dv_i=1 & other -> DROP.
//   PRE: dv=0 -> IDLE. 0x5 -> pre_cnt++ (saturate). 0xD & pre_cnt>=PREAMBLE_MIN -> LO, clear
//        count/CRC/flags. Else -> DROP.
//   LO: dv=1 -> latch low nibble -> HI. dv=0 -> END.
//   HI: dv=1 -> byte={rx_data_i,lo}. If count<2**BUF_AW: next cycle wr_o=1, addr_o=count,
//       data_o=byte, count++. Else set ovf. Feed byte to CRC. -> LO. dv=0 -> END; odd
//       (dribble) nibble discarded silently.
//   END (1 cycle): nbytes_o=count; crc_err_o=(CRC reg!=32'hDEBB20E3)|(count<4)|er_seen;
//       ovf_o=ovf; received_o=1 -> WAIT.
//   WAIT: outputs held. rcv_ack_i=1 -> received_o=0 -> IDLE (if rx_dv_i still 1 -> DROP).
//       Frames arriving in WAIT are not written; they pass through DROP.
//   DROP: no writes; stay while rx_dv_i=1; dv=0 -> IDLE (or WAIT if received_o set).
//   rx_er_i=1 in LO/HI sets er_seen; reception continues.
//   wr_o is a 1-cycle pulse, 1 cycle after high-nibble sample; at most every 2nd cycle.
//   CRC: reflected poly 32'hEDB88320, init FFFFFFFF, byte LSB first, 1 byte/cycle, no final XOR
//     inside block. Good frame => residue DEBB20E3.
//   Count saturates at 2**BUF_AW; nbytes_o reports 2**BUF_AW on overflow.
//   rcv_ack_i outside WAIT ignored. Ack and new dv same cycle: ack wins, new frame -> DROP.
// TESTING
//   1 Preamble 15x5+D, bytes "123456789" + FCS 26 39 F4 CB -> 13 wr_o, addr 0..12,
//     data_o 31..39,26,39,F4,CB; nbytes_o=13, crc_err_o=0, ovf_o=0, received_o=1 until ack.
//   2 Same frame, last FCS byte CB->CA -> nbytes_o=13, crc_err_o=1.
//   3 BUF_AW=4, 20-byte frame -> 16 writes (addr 0..15), ovf_o=1, nbytes_o=16.
//   4 Second frame before rcv_ack_i -> no wr_o, status of frame 1 unchanged;
//     after ack, third frame received normally.
//   5 Preamble 5,5,7,... -> DROP, no wr_o, received_o=0; 1 nibble 5 then D with PREAMBLE_MIN=2 -> DROP.
//   6 rst_i pulsed mid-payload -> outputs 0 next cycle, no writes until dv low then new frame;
//     rx_er_i pulse mid-frame -> crc_err_o=1.

Source files
------------

// File: rtl/iob_eth_rx_if.sv
// MII receive engine bus bundle: PHY nibble input, CSR ack, frame-buffer write port and status.
interface iob_eth_rx_if #(
   parameter int unsigned BUF_AW = 11
);
   logic              rx_dv_i;
   logic [3:0]        rx_data_i;
   logic              rx_er_i;
   logic              rcv_ack_i;
   logic              wr_o;
   logic [BUF_AW-1:0] addr_o;
   logic [7:0]        data_o;
   logic              received_o;
   logic [BUF_AW:0]   nbytes_o;
   logic              crc_err_o;
   logic              ovf_o;

   modport master (
      output rx_dv_i, rx_data_i, rx_er_i, rcv_ack_i,
      input  wr_o, addr_o, data_o, received_o, nbytes_o, crc_err_o, ovf_o
   );

   modport slave (
      input  rx_dv_i, rx_data_i, rx_er_i, rcv_ack_i,
      output wr_o, addr_o, data_o, received_o, nbytes_o, crc_err_o, ovf_o
   );
endinterface

// File: rtl/iob_eth_rx.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes, writes the RX buffer,
// checks CRC-32 over the whole post-SFD stream and holds frame status until acknowledged.
module iob_eth_rx #(
   parameter int unsigned BUF_AW       = 11,
   parameter int unsigned PREAMBLE_MIN = 2
) (
   input  logic           rx_clk_i,
   input  logic           rst_i,
   iob_eth_rx_if.slave    eth
);
   localparam int unsigned CW      = BUF_AW + 1;
   localparam int unsigned PCW     = $clog2(PREAMBLE_MIN + 2);
   localparam logic [CW-1:0] CAP   = CW'(1) << BUF_AW;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_LO, S_HI, S_END, S_WAIT, S_DROP
   } state_t;

   state_t             state_q;
   logic [PCW-1:0]     pre_cnt_q;
   logic [3:0]         lo_q;
   logic [CW-1:0]      cnt_q;
   logic [31:0]        crc_q;
   logic               ovf_q;
   logic               er_q;
   logic               wr_q;
   logic [BUF_AW-1:0]  addr_q;
   logic [7:0]         data_q;
   logic               received_q;
   logic [CW-1:0]      nbytes_q;
   logic               crc_err_q;
   logic               ovf_out_q;

   logic [7:0]         byte_d;
   logic [31:0]        crc_d;

   // Reflected CRC-32, one byte per call, LSB first
   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   always_comb begin
      byte_d = {eth.rx_data_i, lo_q};
      crc_d  = crc_byte(crc_q, byte_d);
   end

   always_ff @(posedge rx_clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         pre_cnt_q  <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         crc_q      <= CRC_INIT;
         ovf_q      <= 1'b0;
         er_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         received_q <= 1'b0;
         nbytes_q   <= '0;
         crc_err_q  <= 1'b0;
         ovf_out_q  <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (eth.rx_dv_i) begin
                  if (eth.rx_data_i == 4'h5) begin
                     state_q   <= S_PRE;
                     pre_cnt_q <= PCW'(1);
                  end else begin
                     state_q <= S_DROP;
                  end
               end
            end
            S_PRE: begin
               if (!eth.rx_dv_i) begin
                  state_q <= S_IDLE;
               end else if (eth.rx_data_i == 4'h5) begin
                  if (pre_cnt_q < PCW'(PREAMBLE_MIN)) pre_cnt_q <= pre_cnt_q + PCW'(1);
               end else if (eth.rx_data_i == 4'hD && pre_cnt_q >= PCW'(PREAMBLE_MIN)) begin
                  state_q <= S_LO;
                  cnt_q   <= '0;
                  crc_q   <= CRC_INIT;
                  ovf_q   <= 1'b0;
                  er_q    <= 1'b0;
               end else begin
                  state_q <= S_DROP;
               end
            end
            S_LO: begin
               if (eth.rx_er_i) er_q <= 1'b1;
               if (eth.rx_dv_i) begin
                  lo_q    <= eth.rx_data_i;
                  state_q <= S_HI;
               end else begin
                  state_q <= S_END;
               end
            end
            S_HI: begin
               if (eth.rx_er_i) er_q <= 1'b1;
               // A trailing lone nibble (dribble) falls through to END without a write
               if (eth.rx_dv_i) begin
                  if (cnt_q < CAP) begin
                     wr_q   <= 1'b1;
                     addr_q <= cnt_q[BUF_AW-1:0];
                     data_q <= byte_d;
                     cnt_q  <= cnt_q + CW'(1);
                  end else begin
                     ovf_q <= 1'b1;
                  end
                  crc_q   <= crc_d;
                  state_q <= S_LO;
               end else begin
                  state_q <= S_END;
               end
            end
            S_END: begin
               nbytes_q   <= cnt_q;
               crc_err_q  <= (crc_q != CRC_RES) | (cnt_q < CW'(4)) | er_q;
               ovf_out_q  <= ovf_q;
               received_q <= 1'b1;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (eth.rcv_ack_i) begin
                  received_q <= 1'b0;
                  state_q    <= eth.rx_dv_i ? S_DROP : S_IDLE;
               end else if (eth.rx_dv_i) begin
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               if (!eth.rx_dv_i) state_q <= received_q ? S_WAIT : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign eth.wr_o       = wr_q;
   assign eth.addr_o     = addr_q;
   assign eth.data_o     = data_q;
   assign eth.received_o = received_q;
   assign eth.nbytes_o   = nbytes_q;
   assign eth.crc_err_o  = crc_err_q;
   assign eth.ovf_o      = ovf_out_q;
endmodule

// File: tb/tb_iob_eth_rx.sv
// Directed bench for iob_eth_rx: buffer writes checked against a scoreboard queue,
// frame status checked with immediate assertions.
module tb_iob_eth_rx;
   localparam int unsigned BUF_AW       = 4;
   localparam int unsigned PREAMBLE_MIN = 2;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [BUF_AW-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iob_eth_rx_if #(.BUF_AW(BUF_AW)) eth ();

   iob_eth_rx #(.BUF_AW(BUF_AW), .PREAMBLE_MIN(PREAMBLE_MIN)) dut (
      .rx_clk_i (clk),
      .rst_i    (rst),
      .eth      (eth)
   );

   wr_t exp_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fcs32(input bq_t b);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (b[i])
         for (int k = 0; k < 8; k++)
            c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return ~c;
   endfunction

   function automatic bq_t with_fcs(input bq_t b);
      bq_t         r = b;
      logic [31:0] f = fcs32(b);
      r.push_back(f[7:0]);
      r.push_back(f[15:8]);
      r.push_back(f[23:16]);
      r.push_back(f[31:24]);
      return r;
   endfunction

   task automatic nib(input logic dv, input logic [3:0] d, input logic er);
      @(negedge clk);
      eth.rx_dv_i   = dv;
      eth.rx_data_i = d;
      eth.rx_er_i   = er;
   endtask

   task automatic send_frame(input bq_t b, input int npre, input bit exp_wr, input int er_idx);
      for (int p = 0; p < npre; p++) nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'hD, 1'b0);
      foreach (b[i]) begin
         nib(1'b1, b[i][3:0], 1'(i == er_idx));
         nib(1'b1, b[i][7:4], 1'b0);
         if (exp_wr && i < (1 << BUF_AW)) exp_q.push_back(wr_t'{addr: BUF_AW'(i), data: b[i]});
      end
      nib(1'b0, 4'h0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) nib(1'b0, 4'h0, 1'b0);
   endtask

   task automatic wait_rcv(input string tag);
      int k = 0;
      while (eth.received_o !== 1'b1 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(eth.received_o), 32'd1);
   endtask

   task automatic chk_status(input string tag, input int nb, input logic ce, input logic ov);
      chk({tag, "_nbytes"},  32'(eth.nbytes_o),  32'(nb));
      chk({tag, "_crc_err"}, 32'(eth.crc_err_o), 32'(ce));
      chk({tag, "_ovf"},     32'(eth.ovf_o),     32'(ov));
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic ack(input string tag);
      @(negedge clk);
      eth.rcv_ack_i = 1'b1;
      @(negedge clk);
      eth.rcv_ack_i = 1'b0;
      chk({tag, "_ack_clears"}, 32'(eth.received_o), 32'd0);
   endtask

   initial begin
      bq_t good, bad, big, pa, pb, pc;
      wr_t got, e;

      eth.rx_dv_i   = 1'b0;
      eth.rx_data_i = 4'h0;
      eth.rx_er_i   = 1'b0;
      eth.rcv_ack_i = 1'b0;

      // Scoreboard consumer: every buffer write must match the next expected one
      fork
         forever begin
            @(negedge clk);
            if (eth.wr_o === 1'b1) begin
               got = {eth.addr_o, eth.data_o};
               chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("wr_addr", 32'(got.addr), 32'(e.addr));
                  chk("wr_data", 32'(got.data), 32'(e.data));
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_wr", 32'(eth.wr_o), 32'd0);
      chk("rst_received", 32'(eth.received_o), 32'd0);
      chk("rst_nbytes", 32'(eth.nbytes_o), 32'd0);
      chk("rst_crc_err", 32'(eth.crc_err_o), 32'd0);
      chk("rst_ovf", 32'(eth.ovf_o), 32'd0);
      rst = 1'b0;
      idle(2);

      // Good frame "123456789" + FCS
      good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
      send_frame(good, 15, 1'b1, -1);
      wait_rcv("t1_received");
      chk_status("t1", 13, 1'b0, 1'b0);
      idle(5);
      chk("t1_held", 32'(eth.received_o), 32'd1);
      ack("t1");
      idle(2);

      // Corrupted last FCS byte
      bad = good;
      bad[12] = 8'hCA;
      send_frame(bad, 15, 1'b1, -1);
      wait_rcv("t2_received");
      chk_status("t2", 13, 1'b1, 1'b0);
      ack("t2");
      idle(2);

      // 20-byte frame into a 16-byte buffer
      big = {};
      for (int i = 0; i < 16; i++) big.push_back(8'(i * 7 + 1));
      big = with_fcs(big);
      send_frame(big, 7, 1'b1, -1);
      wait_rcv("t3_received");
      chk_status("t3", 16, 1'b0, 1'b1);
      ack("t3");
      idle(2);

      // Frame while previous status pending is dropped; next one after ack is accepted
      pa = with_fcs('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
      pb = with_fcs('{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77});
      pc = with_fcs('{8'hF0, 8'h0F, 8'h5A, 8'hA5, 8'h3C});
      send_frame(pa, 7, 1'b1, -1);
      wait_rcv("t4a_received");
      chk_status("t4a", 8, 1'b0, 1'b0);
      idle(2);
      send_frame(pb, 7, 1'b0, -1);
      idle(4);
      chk("t4b_still_received", 32'(eth.received_o), 32'd1);
      chk_status("t4b", 8, 1'b0, 1'b0);
      ack("t4b");
      idle(2);
      send_frame(pc, 7, 1'b1, -1);
      wait_rcv("t4c_received");
      chk_status("t4c", 9, 1'b0, 1'b0);
      ack("t4c");
      idle(2);

      // Bad preamble, then too-short preamble
      nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'h7, 1'b0);
      nib(1'b1, 4'hD, 1'b0);
      nib(1'b1, 4'h1, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      idle(6);
      chk("t5a_no_received", 32'(eth.received_o), 32'd0);
      send_frame(good, 1, 1'b0, -1);
      idle(6);
      chk("t5b_no_received", 32'(eth.received_o), 32'd0);

      // Reset in the middle of the payload
      nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'hD, 1'b0);
      nib(1'b1, 4'h1, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      exp_q.push_back(wr_t'{addr: BUF_AW'(0), data: 8'h31});
      nib(1'b1, 4'h2, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      exp_q.push_back(wr_t'{addr: BUF_AW'(1), data: 8'h32});
      nib(1'b1, 4'h4, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      eth.rx_data_i = 4'h3;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_wr", 32'(eth.wr_o), 32'd0);
      chk("t6_rst_received", 32'(eth.received_o), 32'd0);
      chk("t6_rst_nbytes", 32'(eth.nbytes_o), 32'd0);
      chk("t6_rst_sb", 32'(exp_q.size()), 32'd0);
      eth.rx_data_i = 4'h3;
      nib(1'b1, 4'h4, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      nib(1'b1, 4'h5, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      nib(1'b1, 4'h6, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
      idle(6);
      chk("t6_tail_no_received", 32'(eth.received_o), 32'd0);

      // rx_er_i pulse mid-frame marks an otherwise good frame as bad
      send_frame(good, 7, 1'b1, 4);
      wait_rcv("t6_er_received");
      chk_status("t6_er", 13, 1'b1, 1'b0);
      ack("t6_er");
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
